// File: rtl/mul_pkg.sv
// mul_pkg: constants and helpers shared by the significand multiplier stages.
//   SIG_W     - significand width (hidden bit included)
//   PP_ROWS   - number of AND-array partial-product rows
//   PP_STRIDE - bit stride of one row inside the flattened row bus (2*SIG_W)
//   pp_row()  - one AND-array row: b_bit ? (a << i) : 0, zero-extended
package mul_pkg;

    localparam int unsigned SIG_W     = 24;
    localparam int unsigned PP_ROWS   = SIG_W;
    localparam int unsigned PP_STRIDE = 2 * SIG_W;

    function automatic logic [PP_STRIDE-1:0] pp_row(
        input logic [SIG_W-1:0] a,
        input logic             b_bit,
        input int unsigned      i
    );
        logic [PP_STRIDE-1:0] w_ext;
        w_ext = {{SIG_W{1'b0}}, a};
        return b_bit ? (w_ext << i) : '0;
    endfunction

endpackage

// File: rtl/mul_pipe_reg.sv
// mul_pipe_reg: one elastic register slice with valid/ready handshake.
//   i_clk, i_rst   - clock, synchronous active-high reset (clears valid and data)
//   i_flush        - drop the held beat on the next edge
//   i_valid/o_ready/i_data  - upstream side; o_ready = slice empty or draining
//   o_valid/i_ready/o_data  - downstream side
module mul_pipe_reg #(
    parameter int unsigned DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);

    logic          r_v;
    logic [DW-1:0] r_data;

    // Slice advances when empty or when its beat leaves this cycle.
    assign o_ready = !r_v | i_ready;
    assign o_valid = r_v;
    assign o_data  = r_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v    <= 1'b0;
            r_data <= '0;
        end else begin
            if (i_flush)
                r_v <= 1'b0;
            else if (o_ready)
                r_v <= i_valid;
            // Data only moves with a real beat so stalled contents stay bit-exact.
            if (o_ready && i_valid)
                r_data <= i_data;
        end
    end

endmodule

// File: rtl/mul_pp_gen_pipe.sv
// mul_pp_gen_pipe: significand multiplier front end. Registers two W-bit
// operands (S1), forms the W AND-array partial-product rows and a zero flag,
// and registers them (S2) for the column compressors.
//   clk, rst           - clock, synchronous active-high reset
//   flush              - discard all in-flight beats
//   in_valid/in_ready  - operand handshake (in_a, in_b, in_tag)
//   out_valid/out_ready- row handshake (out_pp, out_zero, out_tag)
//   out_pp             - row i at bits [i*2W +: 2W]
// W must equal mul_pkg::SIG_W since rows are built with mul_pkg::pp_row.
module mul_pp_gen_pipe
    import mul_pkg::*;
#(
    parameter int unsigned W     = SIG_W,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W*2*W-1:0]   out_pp,
    output logic               out_zero,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int unsigned RW   = 2 * W;
    localparam int unsigned S1_W = 2 * W + TAG_W;
    localparam int unsigned S2_W = 1 + TAG_W + W * RW;

    logic              w_s1_adv;
    logic              w_s2_adv;
    logic              w_s1_v;
    logic [S1_W-1:0]   w_s1_data;
    logic [S2_W-1:0]   w_s2_data;
    logic [W-1:0]      w_a;
    logic [W-1:0]      w_b;
    logic [TAG_W-1:0]  w_tag;
    logic [W*RW-1:0]   w_pp;
    logic              w_zero;

    // Combinational from out_ready through both slices' advance terms.
    assign in_ready = w_s1_adv & !flush & !rst;

    mul_pipe_reg #(.DW(S1_W)) u_s1 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .i_valid (in_valid & in_ready),
        .o_ready (w_s1_adv),
        .i_data  ({in_tag, in_b, in_a}),
        .o_valid (w_s1_v),
        .i_ready (w_s2_adv),
        .o_data  (w_s1_data)
    );

    assign w_a   = w_s1_data[W-1:0];
    assign w_b   = w_s1_data[2*W-1:W];
    assign w_tag = w_s1_data[2*W +: TAG_W];

    always_comb begin
        w_pp = '0;
        for (int unsigned i = 0; i < W; i++)
            w_pp[i*RW +: RW] = pp_row(w_a, w_b[i], i);
    end

    assign w_zero = (w_a == '0) | (w_b == '0);

    mul_pipe_reg #(.DW(S2_W)) u_s2 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .i_valid (w_s1_v),
        .o_ready (w_s2_adv),
        .i_data  ({w_zero, w_tag, w_pp}),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_s2_data)
    );

    assign out_pp   = w_s2_data[W*RW-1:0];
    assign out_tag  = w_s2_data[W*RW +: TAG_W];
    assign out_zero = w_s2_data[S2_W-1];

endmodule

// File: doc/mul_pp_gen_pipe.md
Name: mul_pp_gen_pipe

Overview:
- Upstream stage of the significand multiplier. Accepts two W-bit significands through a valid/ready handshake and forms the W AND-array partial-product rows.
- Holds the operands and rows in a 2-stage elastic pipeline. Presents the rows as one flattened bus from which the first-stage column compressors (full/half-adder banks per bit column) pick their operand bits.
- Also produces a zero-operand flag and carries a tag through unchanged.

Parameters:
- W, 24, significand width (hidden bit included)
- TAG_W, 4, width of the sideband tag

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- flush  input  1  discard all in-flight beats
- in_valid  input  1  operand beat offered
- in_ready  output  1  stage can accept a beat this cycle
- in_a  input  W  multiplicand significand
- in_b  input  W  multiplier significand
- in_tag  input  TAG_W  sideband, returned unchanged
- out_valid  output  1  partial products valid
- out_ready  input  1  compressor stage accepts
- out_pp  output  W*2W  row i at bits [i*2W +: 2W]; row i = b[i] ? (a << i) : 0, zero-extended to 2W
- out_zero  output  1  a==0 or b==0
- out_tag  output  TAG_W  tag of the presented beat

Behaviour:
- Stage S1 registers a, b, tag and a valid bit s1_v.
- Stage S2 registers the pp rows computed from S1, the zero flag, the tag and a valid bit s2_v.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_valid = s2_v.
- Advance rules:
  - s2_adv = !s2_v | out_ready.
  - s1_adv = !s1_v | s2_adv.
  - in_ready = s1_adv & !flush & !rst. This is combinational from out_ready; no register in the path.
- S2 loads when s2_adv. In that case s2_v <= s1_v and the data is loaded only when s1_v=1.
- S1 loads when s1_adv. In that case s1_v <= (in_valid & in_ready).
- Latency: a beat accepted in cycle N appears on out_valid in cycle N+2 if not stalled.
- Throughput: one beat per cycle with out_ready=1.
- Stall: while out_valid & !out_ready, out_pp, out_zero and out_tag hold stable, bit-exact. Up to 2 beats are buffered. in_ready falls only when both stages are full and out_ready=0.
- Ordering: beats leave strictly in acceptance order. No beat is dropped or duplicated.
- Flush: on the next edge s1_v and s2_v go to 0. A beat offered in the flush cycle is not accepted (in_ready=0). Data registers are don't-care after flush.
- Flush and out_ready=1 in the same cycle: the S2 beat is still consumed that cycle, then both stages are empty.
- Reset: on the first edge with rst=1, s1_v=s2_v=0, out_valid=0, out_pp=0, out_zero=0, out_tag=0 and the S1 data registers are 0. Reset mid-stall drops the buffered beats.
- Width rules:
  - Each row is exactly 2W bits. Row i occupies bits [i, i+W-1] within its row; all other bits are 0.
  - The row sum of all rows equals a*b exactly (2W bits, no overflow).
- Zero flag: computed in S1→S2 from the registered operands. When out_zero=1 every row is 0.

Decomposition:
- Shared package mul_pkg holds:
  - constants SIG_W=24 and PP_ROWS=SIG_W;
  - a function pp_row(a, b_bit, i) returning the 2W-bit row;
  - the localparam for row stride 2W, used here and by the column compressors.
- One sub-module: mul_pipe_reg. It is a single elastic register slice with valid/ready, flush and a data width parameter, instantiated twice. The pp generation sits combinationally between the two slices.

Test Plan:
- Basic: a=24'h800000, b=24'h800000, out_ready=1 → out_valid 2 cycles later; row 23 = 1<<46 and all other rows 0; out_zero=0; the sum of rows is 48'h400000000000.
- Zero: a=24'h000000, b=24'hABCDEF → out_zero=1 and out_pp all zeros; then a=24'hFFFFFF, b=0 → out_zero=1.
- Streaming: 4 back-to-back beats with tags 1..4, random operands, out_ready=1 → outputs on 4 consecutive cycles starting 2 after the first acceptance, tags in order 1..4, and each row sum equals the reference product.
- Backpressure: out_ready=0 while 3 beats are offered → exactly 2 accepted and in_ready=0 on the 3rd; outputs stable across the stall; raise out_ready → all 3 emerge in order, with no loss or duplicates.
- Flush: 2 beats in flight plus flush=1 with in_valid=1 → next cycle out_valid=0; the flush-cycle beat is not accepted; the next beat after flush has normal 2-cycle latency.
- Reset mid-operation: rst=1 with both stages full and out_ready=0 → next cycle out_valid=0, out_pp=0, out_tag=0 and in_ready=1 once rst is deasserted.
